// File: rtl/risc_v_pipeline_pkg.sv
// Shared pipeline definitions: immediate format encodings, output buffer depth,
// and a sign-extension helper used by the optional immediate range check.
package risc_v_pipeline_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_e;

  localparam int unsigned IMM_BUF_DEPTH = 2;
  localparam int unsigned IMM_PAYLOAD_W = 33;

  // True when v[31:msb] are all equal, i.e. v is the sign-extension of v[msb:0].
  function automatic logic is_sext(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_enc_buf.sv
// Two-entry in-order output buffer with valid/ready on both sides.
// A beat transfers on a rising edge where valid and ready are both 1.
module imm_enc_buf
  import risc_v_pipeline_pkg::*;
#(
  parameter int unsigned W = IMM_PAYLOAD_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  localparam logic [1:0] DEPTH_C = 2'(IMM_BUF_DEPTH);

  logic [W-1:0] mem_q [IMM_BUF_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         live_q;
  logic         push, pop;

  // live_q keeps ready low through reset and raises it on the first edge after.
  assign in_ready_o  = live_q && (cnt_q != DEPTH_C);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(IMM_BUF_DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      live_q   <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      live_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/imm_enc.sv
// Immediate packer: merges imm_i into base_i per format, buffered by imm_enc_buf.
// Define IMM_RANGE_CHECK_EN to add range/alignment checking and the error counter.
module imm_enc
  import risc_v_pipeline_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  imm_sel_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] inst_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic [15:0] err_cnt_o
);

  logic [31:0] inst_d;
  logic        err_d;
  logic        in_acc;

  assign in_acc = valid_i && ready_o;

  // Only immediate bit positions are overwritten; everything else is base_i.
  always_comb begin
    inst_d = base_i;
    case (imm_sel_i)
      IMM_I: inst_d[31:20] = imm_i[11:0];
      IMM_S: begin
        inst_d[31:25] = imm_i[11:5];
        inst_d[11:7]  = imm_i[4:0];
      end
      IMM_B: begin
        inst_d[31]    = imm_i[12];
        inst_d[7]     = imm_i[11];
        inst_d[30:25] = imm_i[10:5];
        inst_d[11:8]  = imm_i[4:1];
      end
      IMM_J: begin
        inst_d[31]    = imm_i[20];
        inst_d[19:12] = imm_i[19:12];
        inst_d[20]    = imm_i[11];
        inst_d[30:21] = imm_i[10:1];
      end
      IMM_U: inst_d[31:12] = imm_i[31:12];
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_d = 1'b0;
    case (imm_sel_i)
      IMM_I, IMM_S: err_d = !is_sext(imm_i, 11);
      IMM_B:        err_d = !is_sext(imm_i, 12) || imm_i[0];
      IMM_J:        err_d = !is_sext(imm_i, 20) || imm_i[0];
      IMM_U:        err_d = (imm_i[11:0] != 12'h0);
      default:      err_d = 1'b1;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_acc && err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= 16'h0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_d     = 1'b0;
  assign err_cnt_o = 16'h0;
`endif

  imm_enc_buf #(.W(IMM_PAYLOAD_W)) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (valid_i),
    .in_ready_o (ready_o),
    .in_data_i  ({err_d, inst_d}),
    .out_valid_o(valid_o),
    .out_ready_i(ready_i),
    .out_data_o ({err_o, inst_o})
  );

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: directed steps plus random traffic against a queue-based
// reference model; error expectations follow IMM_RANGE_CHECK_EN when defined.
module tb_imm_enc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  imm_sel_i;
  logic [31:0] imm_i;
  logic [31:0] base_i;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;
  logic [15:0] err_cnt_o;

  imm_enc dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .imm_sel_i(imm_sel_i),
    .imm_i    (imm_i),
    .base_i   (base_i),
    .inst_o   (inst_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard state: expected beats in order ({err, inst}), error count, ready-enable.
  logic [32:0] exp_q[$];
  int          err_cnt_m = 0;
  logic        live = 1'b0;
  int          total = 0;
  int          bad = 0;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: mask of immediate positions plus the field value assembled by shifts.
  function automatic logic [32:0] ref_beat(input logic [2:0] s, input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] mask, field;
    logic        err;
    int          v;
    v = $signed(imm);
    mask = 32'h0; field = 32'h0; err = 1'b0;
    case (s)
      3'd0: begin
        mask = 32'hFFF0_0000; field = imm << 20;
        err = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        mask = 32'hFE00_0F80;
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        mask = 32'hFE00_0F80;
        field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7)
              | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
        err = (v < -4096) || (v > 4095) || ((imm % 32'd2) != 32'd0);
      end
      3'd3: begin
        mask = 32'hFFFF_F000;
        field = (((imm >> 20) & 32'h1) << 31) | (imm & 32'h000F_F000)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
        err = (v < -1048576) || (v > 1048575) || ((imm % 32'd2) != 32'd0);
      end
      3'd4: begin
        mask = 32'hFFFF_F000; field = imm & 32'hFFFF_F000;
        err = (imm % 32'd4096) != 32'd0;
      end
      default: err = 1'b1;
    endcase
    return {err & CHK_EN, (base & ~mask) | (field & mask)};
  endfunction

  // One cycle: drive inputs, check outputs against model, clock, update model.
  task automatic step(input logic v, input logic [2:0] s, input logic [31:0] imm,
                      input logic [31:0] base, input logic rdy);
    logic        acc, ret;
    logic [32:0] beat;
    valid_i = v; imm_sel_i = s; imm_i = imm; base_i = base; ready_i = rdy;
    #1;
    chk("ready_o", 33'(ready_o), 33'(live && (exp_q.size() < 2)));
    chk("valid_o", 33'(valid_o), 33'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("head_beat", {err_o, inst_o}, exp_q[0]);
    acc  = v && live && (exp_q.size() < 2);
    ret  = rdy && (exp_q.size() > 0);
    beat = ref_beat(s, imm, base);
    @(posedge clk_i);
    #1;
    if (ret) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(beat);
      if (beat[32] && err_cnt_m < 65535) err_cnt_m++;
    end
    live = 1'b1;
    chk("err_cnt_o", 33'(err_cnt_o), 33'(err_cnt_m));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 3'd0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] r, imm;
    int          k;
    rst_i = 1'b1; valid_i = 1'b0; imm_sel_i = 3'd0; imm_i = 32'h0; base_i = 32'h0; ready_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid_o", 33'(valid_o), 33'd0);
    chk("rst_inst_o", 33'(inst_o), 33'd0);
    chk("rst_err_o", 33'(err_o), 33'd0);
    chk("rst_err_cnt_o", 33'(err_cnt_o), 33'd0);
    chk("rst_ready_o", 33'(ready_o), 33'd0);
    rst_i = 1'b0;
    idle(1'b1);

    // I-type, one-cycle latency
    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 1'b1);
    chk("i_valid_o", 33'(valid_o), 33'd1);
    chk("i_inst_o", 33'(inst_o), 33'h0FFF0_0093);
    chk("i_err_o", 33'(err_o), 33'd0);
    idle(1'b1);

    // B-type then J-type back to back
    step(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 1'b1);
    chk("b_inst_o", 33'(inst_o), 33'h0FE00_0EE3);
    step(1'b1, 3'd3, 32'h0000_0008, 32'h0000_006F, 1'b1);
    chk("j_inst_o", 33'(inst_o), 33'h00080_006F);
    idle(1'b1);

    // U-type, aligned and misaligned
    step(1'b1, 3'd4, 32'h1234_5000, 32'h0000_02B7, 1'b1);
    chk("u_inst_o", 33'(inst_o), 33'h01234_52B7);
    chk("u_err_o", 33'(err_o), 33'd0);
    step(1'b1, 3'd4, 32'h1234_5001, 32'h0000_02B7, 1'b1);
    chk("u_bad_inst_o", 33'(inst_o), 33'h01234_52B7);
    chk("u_bad_err_o", 33'(err_o), 33'(CHK_EN));
    chk("u_bad_err_cnt_o", 33'(err_cnt_o), 33'(CHK_EN));
    idle(1'b1);

    // Backpressure: three offers, only two accepted, then drain in order
    step(1'b1, 3'd0, 32'h0000_0123, 32'h0000_0013, 1'b0);
    step(1'b1, 3'd1, 32'hFFFF_F800, 32'h0000_2023, 1'b0);
    chk("bp_ready_o_full", 33'(ready_o), 33'd0);
    step(1'b1, 3'd4, 32'hABCD_E000, 32'h0000_0037, 1'b0);
    chk("bp_third_refused", 33'(exp_q.size()), 33'd2);
    repeat (3) idle(1'b1);
    chk("bp_drained_valid_o", 33'(valid_o), 33'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      k = $urandom_range(11, 21);
      case ($urandom_range(0, 2))
        0: imm = r;
        1: imm = 32'($signed(r << k) >>> k);
        default: imm = 32'($signed(r << k) >>> k) & 32'hFFFF_FFFE;
      endcase
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), imm, $urandom,
           1'($urandom_range(0, 3) != 0));
    end
    repeat (3) idle(1'b1);

    // Mid-operation reset with two beats buffered
    for (int n = 0; n < 4 && exp_q.size() < 2; n++)
      step(1'b1, 3'd7, 32'h5555_0001, 32'h0000_0033, 1'b0);
    chk("pre_rst_occupancy", 33'(exp_q.size()), 33'd2);
    valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid_o", 33'(valid_o), 33'd0);
    chk("mid_rst_err_cnt_o", 33'(err_cnt_o), 33'd0);
    chk("mid_rst_ready_o", 33'(ready_o), 33'd0);
    chk("mid_rst_inst_o", 33'(inst_o), 33'd0);
    exp_q.delete();
    err_cnt_m = 0;
    live = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_no_stale", 33'(valid_o), 33'd0);
    for (int n = 0; n < 20; n++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
           1'($urandom_range(0, 1)));
    repeat (3) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
